// File: rtl/multi_prbs_pkg.sv
// multi_prbs_pkg: shared types, polynomial constants and LFSR helpers for multi_prbs_gen_check.
// Helpers operate on 64-bit containers; the active width is passed in and upper bits stay zero.
// Consumers: prbs_chk_lane, multi_prbs_gen_check (optional feature macro: PRBS_ERR_INJECT_EN).
package multi_prbs_pkg;

  localparam int unsigned MAX_W = 64;

  localparam logic [MAX_W-1:0] PRBS7_POLY     = 64'h60;
  localparam logic [MAX_W-1:0] PRBS15_POLY    = 64'h6000;
  localparam logic [MAX_W-1:0] POLY32_DEFAULT = 64'h8000_0057;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // Per-lane checker state. Wide fields are sized for the largest lane; the
  // lane only ever sets bits inside its configured width.
  typedef struct packed {
    chk_state_e       state;
    logic [MAX_W-1:0] pred;
    logic             have_prev;
    logic [31:0]      match_cnt;
    logic [31:0]      bad_cnt;
    logic [MAX_W-1:0] err_count;
    logic [MAX_W-1:0] word_count;
  } chk_lane_t;

  function automatic logic [MAX_W-1:0] width_mask(input int unsigned width);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Advance a Fibonacci LFSR 'steps' times: feedback = ^(state & poly) enters at the LSB.
  function automatic logic [MAX_W-1:0] lfsr_advance(input logic [MAX_W-1:0] state,
                                                    input logic [MAX_W-1:0] poly,
                                                    input int unsigned      width,
                                                    input int unsigned      steps);
    logic [MAX_W-1:0] s;
    logic [MAX_W-1:0] m;
    m = width_mask(width);
    s = state & m;
    for (int unsigned i = 0; i < steps; i++) begin
      s = ((s << 1) | {{(MAX_W-1){1'b0}}, ^(s & poly)}) & m;
    end
    return s;
  endfunction

  function automatic logic [6:0] popcount(input logic [MAX_W-1:0] x);
    logic [6:0] c;
    c = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      c = c + {6'd0, x[i]};
    end
    return c;
  endfunction

  // Saturating add inside a 'width'-bit counter; 'a' is assumed already in range.
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int unsigned      width);
    logic [MAX_W:0]   sum;
    logic [MAX_W-1:0] m;
    m   = width_mask(width);
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, m}) return m;
    return sum[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/prbs_chk_lane.sv
// prbs_chk_lane: single-channel self-synchronising PRBS checker with lock FSM and saturating counters.
// Ports: clk_i/reset_i (sync, active-high), clr_i counter clear, vld_i/rx_i input beat,
//        locked_o lock flag, err_count_o bit errors, word_count_o checked words (all registered).
module prbs_chk_lane
  import multi_prbs_pkg::*;
#(
  parameter int unsigned      DATA_WIDTH    = 32,
  parameter logic [MAX_W-1:0] POLY          = POLY32_DEFAULT,
  parameter int unsigned      ITERATIONS    = 32,
  parameter int unsigned      LOCK_COUNT    = 8,
  parameter int unsigned      UNLOCK_COUNT  = 4,
  parameter int unsigned      ERR_CNT_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clr_i,
  input  logic                     vld_i,
  input  logic [DATA_WIDTH-1:0]    rx_i,
  output logic                     locked_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic [ERR_CNT_WIDTH-1:0] word_count_o
);

  chk_lane_t        lane_q, lane_d;
  logic [MAX_W-1:0] rx_w;
  logic [MAX_W-1:0] adv_rx;
  logic [MAX_W-1:0] adv_pred;
  logic [6:0]       bit_errs;

  always_comb begin
    rx_w = '0;
    rx_w[DATA_WIDTH-1:0] = rx_i;
  end

  assign adv_rx   = lfsr_advance(rx_w, POLY, DATA_WIDTH, ITERATIONS);
  assign adv_pred = lfsr_advance(lane_q.pred, POLY, DATA_WIDTH, ITERATIONS);
  assign bit_errs = popcount(rx_w ^ lane_q.pred);

  always_comb begin
    lane_d = lane_q;
    if (vld_i) begin
      case (lane_q.state)
        SEARCH: begin
          // While searching, every received word reseeds the predictor.
          lane_d.pred      = adv_rx;
          lane_d.have_prev = 1'b1;
          if (lane_q.have_prev) begin
            if (rx_w == lane_q.pred) begin
              if (lane_q.match_cnt + 32'd1 >= LOCK_COUNT) begin
                lane_d.state     = LOCKED;
                lane_d.match_cnt = '0;
                lane_d.bad_cnt   = '0;
              end else begin
                lane_d.match_cnt = lane_q.match_cnt + 32'd1;
              end
            end else begin
              lane_d.match_cnt = '0;
            end
          end
        end
        LOCKED: begin
          // Free-running predictor: received errors must not corrupt it.
          lane_d.pred       = adv_pred;
          lane_d.word_count = sat_add(lane_q.word_count, 64'd1, ERR_CNT_WIDTH);
          lane_d.err_count  = sat_add(lane_q.err_count, {57'd0, bit_errs}, ERR_CNT_WIDTH);
          if (bit_errs != 7'd0) begin
            if (lane_q.bad_cnt + 32'd1 >= UNLOCK_COUNT) begin
              lane_d.state     = SEARCH;
              lane_d.have_prev = 1'b0;
              lane_d.bad_cnt   = '0;
            end else begin
              lane_d.bad_cnt = lane_q.bad_cnt + 32'd1;
            end
          end else begin
            lane_d.bad_cnt = '0;
          end
        end
        default: lane_d = lane_q;
      endcase
    end
    // Clear overrides any count taken on the same beat.
    if (clr_i) begin
      lane_d.err_count  = '0;
      lane_d.word_count = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) lane_q <= '0;
    else         lane_q <= lane_d;
  end

  assign locked_o     = (lane_q.state == LOCKED);
  assign err_count_o  = lane_q.err_count[ERR_CNT_WIDTH-1:0];
  assign word_count_o = lane_q.word_count[ERR_CNT_WIDTH-1:0];

endmodule

// File: rtl/multi_prbs_gen_check.sv
// multi_prbs_gen_check: N-lane PRBS generator (MODE "GENERATOR") or checker (MODE "CHECKER").
// Ports: clk/reset (sync, active-high), cnt_clear; S_AXIS_* checker input (TREADY tied 1);
//        M_AXIS_* generator output; locked/err_count/word_count per-lane status.
// Optional macro PRBS_ERR_INJECT_EN adds inject_err (bit-0 flip on the next accepted generator word).
module multi_prbs_gen_check
  import multi_prbs_pkg::*;
#(
  parameter int unsigned      DATA_WIDTH    = 32,
  parameter int unsigned      N_CHANNELS    = 1,
  parameter logic [MAX_W-1:0] POLY          = POLY32_DEFAULT,
  parameter int unsigned      ITERATIONS    = 32,
  parameter string            MODE          = "GENERATOR",
  parameter int unsigned      LOCK_COUNT    = 8,
  parameter int unsigned      UNLOCK_COUNT  = 4,
  parameter int unsigned      ERR_CNT_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cnt_clear,
  input  logic [DATA_WIDTH*N_CHANNELS-1:0]    S_AXIS_TDATA,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  output logic [DATA_WIDTH*N_CHANNELS-1:0]    M_AXIS_TDATA,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic [N_CHANNELS-1:0]               locked,
  output logic [ERR_CNT_WIDTH*N_CHANNELS-1:0] err_count,
  output logic [ERR_CNT_WIDTH*N_CHANNELS-1:0] word_count
`ifdef PRBS_ERR_INJECT_EN
  ,
  input  logic                                inject_err
`endif
);

  localparam bit               IS_GEN      = (MODE == "GENERATOR");
  localparam logic [MAX_W-1:0] ACTIVE_ONES = width_mask(DATA_WIDTH);

  // Generator: every lane starts from the same all-ones seed, so one LFSR feeds all lanes.
  logic [MAX_W-1:0]      gen_state_q, gen_state_d;
  logic                  gen_vld_q;
  logic                  gen_fire;
  logic                  inj_bit;
  logic [DATA_WIDTH-1:0] gen_word;

  assign gen_fire    = gen_vld_q & M_AXIS_TREADY;
  assign gen_state_d = gen_fire ? lfsr_advance(gen_state_q, POLY, DATA_WIDTH, ITERATIONS)
                                : gen_state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      gen_state_q <= ACTIVE_ONES;
      gen_vld_q   <= 1'b0;
    end else begin
      gen_state_q <= gen_state_d;
      gen_vld_q   <= 1'b1;
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  // Pending flip survives until a word is accepted; repeat pulses merge into it.
  logic inj_pend_q, inj_pend_d;
  assign inj_pend_d = (inj_pend_q & ~gen_fire) | (inject_err & IS_GEN);
  always_ff @(posedge clk) begin
    if (reset) inj_pend_q <= 1'b0;
    else       inj_pend_q <= inj_pend_d;
  end
  assign inj_bit = inj_pend_q;
`else
  assign inj_bit = 1'b0;
`endif

  assign gen_word      = gen_state_q[DATA_WIDTH-1:0] ^ DATA_WIDTH'(inj_bit);
  assign M_AXIS_TVALID = IS_GEN & gen_vld_q;
  assign S_AXIS_TREADY = 1'b1;

  for (genvar j = 0; j < N_CHANNELS; j++) begin : g_lane
    logic                     lane_locked;
    logic [ERR_CNT_WIDTH-1:0] lane_err;
    logic [ERR_CNT_WIDTH-1:0] lane_words;

    prbs_chk_lane #(
      .DATA_WIDTH   (DATA_WIDTH),
      .POLY         (POLY),
      .ITERATIONS   (ITERATIONS),
      .LOCK_COUNT   (LOCK_COUNT),
      .UNLOCK_COUNT (UNLOCK_COUNT),
      .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
    ) u_lane (
      .clk_i       (clk),
      .reset_i     (reset),
      .clr_i       (cnt_clear),
      .vld_i       (S_AXIS_TVALID),
      .rx_i        (S_AXIS_TDATA[DATA_WIDTH*j +: DATA_WIDTH]),
      .locked_o    (lane_locked),
      .err_count_o (lane_err),
      .word_count_o(lane_words)
    );

    assign M_AXIS_TDATA[DATA_WIDTH*j +: DATA_WIDTH]     = IS_GEN ? gen_word : '0;
    assign locked[j]                                    = IS_GEN ? 1'b0 : lane_locked;
    assign err_count[ERR_CNT_WIDTH*j +: ERR_CNT_WIDTH]  = IS_GEN ? '0 : lane_err;
    assign word_count[ERR_CNT_WIDTH*j +: ERR_CNT_WIDTH] = IS_GEN ? '0 : lane_words;
  end

endmodule

// File: doc/multi_prbs_gen_check.md
Name: multi_prbs_gen_check

Overview:
- Parametrised successor to the team's single-mode LFSR block.
- Per channel, it either generates a PRBS word stream, or checks an incoming stream and reports status.
- Checker status: self-synchronising lock state machine, per-channel bit-error counter, and word counter.
- Sits between the AXI-Stream data path and the link/BERT test registers.

Parameters:
- DATA_WIDTH, 32: LFSR state and word width per channel (8..64).
- N_CHANNELS, 1: number of independent lanes.
- POLY, 32'h80000057: tap mask. Feedback bit = XOR-reduce(state & POLY), shifted in at the LSB.
- ITERATIONS, 32: LFSR steps per word. Must be ≥1.
- MODE, "GENERATOR": "GENERATOR" or "CHECKER".
- LOCK_COUNT, 8: consecutive matching words needed to lock (≥1).
- UNLOCK_COUNT, 4: consecutive errored words that drop lock (≥1).
- ERR_CNT_WIDTH, 32: width of the bit-error and word counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cnt_clear  in  1  synchronous clear of all counters. Lock state is not affected.
- S_AXIS_TDATA  in  DATA_WIDTH*N_CHANNELS  checker input; channel j occupies bits [DATA_WIDTH*j +: DATA_WIDTH].
- S_AXIS_TVALID  in  1  checker input valid.
- S_AXIS_TREADY  out  1  always 1.
- M_AXIS_TDATA  out  DATA_WIDTH*N_CHANNELS  generator output. Driven 0 in CHECKER mode.
- M_AXIS_TVALID  out  1  generator output valid.
- M_AXIS_TREADY  in  1  generator backpressure.
- locked  out  N_CHANNELS  per-channel lock flag.
- err_count  out  ERR_CNT_WIDTH*N_CHANNELS  per-channel bit-error count.
- word_count  out  ERR_CNT_WIDTH*N_CHANNELS  per-channel count of checked words.
- inject_err  in  1  present only with PRBS_ERR_INJECT_EN.

Behaviour:
- Reset, GENERATOR mode:
  - LFSR state = all ones.
  - M_AXIS_TVALID = 0, then 1 from the first cycle after reset deasserts.
  - M_AXIS_TDATA = all ones.
- Reset, CHECKER mode:
  - All channels go to SEARCH and have_prev = 0.
  - locked = 0, err_count = 0, word_count = 0, match counters = 0.
- Generator stepping:
  - M_AXIS_TDATA shows the registered state.
  - Each cycle with TVALID & TREADY, the state advances ITERATIONS steps.
  - With TREADY = 0, the state and data hold.
  - The first word after reset is all ones.
- Checker beat: each cycle with S_AXIS_TVALID = 1, per channel. Below, rx = the channel's input word and adv(x) = x advanced ITERATIONS steps.
  - SEARCH, have_prev = 0:
    - pred <= adv(rx); have_prev <= 1. No compare.
  - SEARCH, have_prev = 1:
    - If rx == pred: match_cnt + 1.
    - Otherwise: match_cnt <= 0.
    - In both cases pred <= adv(rx).
    - When a match makes match_cnt reach LOCK_COUNT: go to LOCKED, match_cnt <= 0, bad_cnt <= 0.
  - LOCKED:
    - pred <= adv(pred). The local LFSR runs free and is no longer reseeded from rx.
    - word_count + 1; err_count += popcount(rx ^ pred).
    - A nonzero popcount increments bad_cnt; a clean word clears it.
    - When bad_cnt reaches UNLOCK_COUNT: go to SEARCH, have_prev <= 0.
- No beat (TVALID = 0): no state, pred or counter changes.
- Counters:
  - Count only while LOCKED.
  - Saturate at all ones and never wrap.
  - The popcount add saturates too: if the sum overflows, the result is all ones.
- Latency: locked and the counters update on the clock edge that accepts the beat. They are visible the following cycle.
- Simultaneous events:
  - cnt_clear with a LOCKED beat: the clear wins and the counters become 0. That beat's errors are discarded.
  - reset beats everything, including mid-lock.
- Each channel is independent; all channels share TVALID.
- adv() is purely combinational: an unrolled ITERATIONS-step loop.

Optional Feature:
- Macro: PRBS_ERR_INJECT_EN.
- Defined:
  - Adds the inject_err port.
  - In GENERATOR mode, a 1 on inject_err is latched. On the next accepted output word, bit 0 of every channel's output is inverted. The internal LFSR state is not corrupted.
  - Further pulses before that word is accepted merge into one pending injection.
  - In CHECKER mode the port is ignored.
- Undefined: no port, no logic.

Decomposition:
- Package multi_prbs_pkg holds:
  - the chk_state_e enum (SEARCH, LOCKED);
  - the per-channel checker struct (state, pred, have_prev, match_cnt, bad_cnt, err_count, word_count);
  - the default polynomial constants (PRBS7 = 'h60, PRBS15 = 'h6000, 32-bit default 'h80000057);
  - the lfsr_advance and popcount functions, parametrised via width arguments.
- One sub-module, prbs_chk_lane: a single-channel checker, instantiated N_CHANNELS times in a generate loop. The top keeps the generator and the stream glue.

Test Plan:
- Loopback, 1 channel: generator output into the checker, TREADY = 1, LOCK_COUNT = 8. After reset, locked rises after beat 10 (1 seed + 8 matches + 1 cycle); then 1000 words give err_count = 0 and word_count = 1000.
- Error injection: while locked, XOR one word with 32'h00000101 → err_count = 2, locked stays 1. XOR 4 consecutive words with 32'h1 → locked = 0 the cycle after the 4th.
- Backpressure: generator with M_AXIS_TREADY toggled 1,0,0,1 → the data word holds during stalls. The sequence equals the free-running sequence with no skips or repeats.
- Checker gaps: TVALID deasserted for 5 cycles mid-stream → no change to counters or lock; the checker resumes matching.
- Saturation/clear: ERR_CNT_WIDTH = 4, inject 20 bit errors while locked → err_count = 15. Asserting cnt_clear in the same cycle as an errored beat → 0.
- Multi-channel (N_CHANNELS = 4, DATA_WIDTH = 16, POLY = 'h6000): corrupt only lane 2 → only lane 2's err_count rises; reset mid-lock clears all lanes the next cycle.
